i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx_pkg.sv | 14 +
 rtl/i2s_rx_sync_2ff.sv | 25 ++
 rtl/i2s_rx.sv | 165 ++++++++++++++++
 tb/tb_i2s_rx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
// Shared definitions for the I2S receiver: default word/slot sizes and FSM encodings.
package i2s_rx_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_SLOT_W = 32;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PAD   = 2'd3
    } state_t;

endpackage

// File: rtl/i2s_rx_sync_2ff.sv
// Two-flop synchronizer for one asynchronous codec line into the CLK domain.
module sync_2ff (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Two-stage capture to settle metastability
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples BCLK/LRCK/SDATA on CLK and presents coherent signed L/R pairs.
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SLOT_W = DEF_SLOT_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              BCLK,
    input  logic              LRCK,
    input  logic              SDATA,
    output logic [DATA_W-1:0] LEFT,
    output logic [DATA_W-1:0] RIGHT,
    output logic              VALID,
    output logic              FRAME_ERR
);

    localparam int CW = $clog2(SLOT_W);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_W - 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(SLOT_W - 1);

    logic              bclk_s, lrck_s, sdata_s;
    logic              bclk_prev_r, rise_r, bit_r, lrck_r, lrck_prev_r, chan_r;
    logic              lrck_edge_s, word_done_s, err_s;
    logic [CW-1:0]     slot_cnt_r, bit_cnt_r;
    logic [DATA_W-1:0] shift_r, word_s, left_hold_r, left_r, right_r;
    logic              left_pend_r, valid_r, err_r;
    state_t            state_r, state_nxt_s;

    sync_2ff u_sync_bclk  (.CLK(CLK), .RST_N(RST_N), .d(BCLK),  .q(bclk_s));
    sync_2ff u_sync_lrck  (.CLK(CLK), .RST_N(RST_N), .d(LRCK),  .q(lrck_s));
    sync_2ff u_sync_sdata (.CLK(CLK), .RST_N(RST_N), .d(SDATA), .q(sdata_s));

    // Registered rise strobe with the LRCK/SDATA values captured alongside it
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bclk_prev_r <= 1'b0;
            rise_r      <= 1'b0;
            bit_r       <= 1'b0;
            lrck_r      <= 1'b0;
        end else begin
            bclk_prev_r <= bclk_s;
            rise_r      <= bclk_s & ~bclk_prev_r;
            bit_r       <= sdata_s;
            lrck_r      <= lrck_s;
        end
    end

    assign lrck_edge_s = rise_r && (lrck_r != lrck_prev_r);
    assign word_s      = {shift_r[DATA_W-2:0], bit_r};

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and strobes; the edge rise itself is the delay bit and carries no data
    always_comb begin
        state_nxt_s = state_r;
        word_done_s = 1'b0;
        err_s       = 1'b0;
        if (rise_r) begin
            case (state_r)
                ST_SYNC: begin
                    if (lrck_edge_s && !lrck_r) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_SYNC;
                    end
                end
                ST_DELAY: begin
                    state_nxt_s = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (lrck_edge_s) begin
                        err_s       = 1'b1;
                        state_nxt_s = ST_SYNC;
                    end else if (bit_cnt_r == LAST_BIT) begin
                        word_done_s = 1'b1;
                        state_nxt_s = ST_PAD;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
                ST_PAD: begin
                    if (lrck_edge_s) begin
                        state_nxt_s = ST_SHIFT;
                    end else if (slot_cnt_r == LAST_SLOT) begin
                        err_s       = 1'b1;
                        state_nxt_s = ST_SYNC;
                    end else begin
                        state_nxt_s = ST_PAD;
                    end
                end
                default: begin
                    state_nxt_s = ST_SYNC;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Slot/bit counters, shift register, left holding register and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lrck_prev_r <= 1'b0;
            chan_r      <= 1'b0;
            slot_cnt_r  <= '0;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            left_hold_r <= '0;
            left_pend_r <= 1'b0;
            left_r      <= '0;
            right_r     <= '0;
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            if (rise_r) begin
                lrck_prev_r <= lrck_r;
                if (lrck_edge_s) begin
                    slot_cnt_r <= '0;
                    chan_r     <= lrck_r;
                end else if (slot_cnt_r != LAST_SLOT) begin
                    slot_cnt_r <= slot_cnt_r + 1'b1;
                end
                if (state_r == ST_SHIFT && !lrck_edge_s) begin
                    shift_r   <= word_s;
                    bit_cnt_r <= bit_cnt_r + 1'b1;
                end else begin
                    bit_cnt_r <= '0;
                end
                // A right word only publishes when a left word from this alignment is waiting
                if (word_done_s) begin
                    if (!chan_r) begin
                        left_hold_r <= word_s;
                        left_pend_r <= 1'b1;
                    end else if (left_pend_r) begin
                        left_r      <= left_hold_r;
                        right_r     <= word_s;
                        valid_r     <= 1'b1;
                        left_pend_r <= 1'b0;
                    end
                end
                if (err_s) begin
                    err_r       <= 1'b1;
                    left_pend_r <= 1'b0;
                end
            end
        end
    end

    assign LEFT      = left_r;
    assign RIGHT     = right_r;
    assign VALID     = valid_r;
    assign FRAME_ERR = err_r;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: codec bit-stream model plus a slot-level reference model.
module tb_i2s_rx;

    localparam int DW   = 24;
    localparam int SW   = 32;
    localparam int HALF = 162;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          BCLK = 1'b0;
    logic          LRCK = 1'b0;
    logic          SDATA = 1'b0;
    logic [DW-1:0] LEFT, RIGHT;
    logic          VALID, FRAME_ERR;

    i2s_rx #(.DATA_W(DW), .SLOT_W(SW)) dut (
        .CLK(CLK), .RST_N(RST_N), .BCLK(BCLK), .LRCK(LRCK), .SDATA(SDATA),
        .LEFT(LEFT), .RIGHT(RIGHT), .VALID(VALID), .FRAME_ERR(FRAME_ERR)
    );

    always #10 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        time           t;
    } pair_t;

    pair_t got_q[$];
    pair_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int exp_errs = 0;
    int wide_pulses = 0;
    int overlaps = 0;
    int glitches = 0;

    // Reference model state, tracked per slot rather than per bit
    bit            m_aligned = 1'b0;
    bit            m_have_left = 1'b0;
    bit            m_skip = 1'b0;
    bit            m_prev_chan = 1'b0;
    logic [DW-1:0] m_left = '0;

    logic          prev_valid = 1'b0, prev_err = 1'b0, prev_rst = 1'b0;
    logic [DW-1:0] prev_l = '0, prev_r = '0;

    // Output monitor sampled on the falling CLK edge
    always @(negedge CLK) begin
        if (VALID) got_q.push_back('{LEFT, RIGHT, $time - 10});
        if (FRAME_ERR && !prev_err) err_pulses++;
        if ((VALID && prev_valid) || (FRAME_ERR && prev_err)) wide_pulses++;
        if (VALID && FRAME_ERR) overlaps++;
        if (RST_N && prev_rst && !VALID && (LEFT !== prev_l || RIGHT !== prev_r)) glitches++;
        prev_valid = VALID;
        prev_err   = FRAME_ERR;
        prev_rst   = RST_N;
        prev_l     = LEFT;
        prev_r     = RIGHT;
    end

    task automatic model_reset();
        m_aligned   = 1'b0;
        m_have_left = 1'b0;
        m_skip      = 1'b0;
        m_prev_chan = 1'b0;
    endtask

    task automatic drive_bit(input logic lr, input logic d, output time t_rise);
        BCLK  = 1'b0;
        LRCK  = lr;
        SDATA = d;
        #HALF;
        BCLK   = 1'b1;
        t_rise = $time;
        #HALF;
    endtask

    // One codec slot of len BCLK periods, then the slot-level expectation update
    task automatic send_slot(input logic ch, input logic [DW-1:0] w, input int len);
        time t;
        time t_lsb;
        bit  start_ok;
        t_lsb = 0;
        for (int k = 0; k < len; k++) begin
            drive_bit(ch, (k >= 1 && k <= DW) ? w[DW-k] : 1'b0, t);
            if (k == DW) t_lsb = t;
        end
        start_ok    = !m_skip && (m_aligned || (ch == 1'b0 && m_prev_chan == 1'b1));
        m_skip      = 1'b0;
        m_prev_chan = ch;
        if (start_ok) begin
            if (len < DW + 1) begin
                exp_errs++;
                m_aligned   = 1'b0;
                m_have_left = 1'b0;
                m_skip      = 1'b1;
            end else begin
                m_aligned = 1'b1;
                if (ch == 1'b0) begin
                    m_left      = w;
                    m_have_left = 1'b1;
                end else if (m_have_left) begin
                    exp_q.push_back('{m_left, w, t_lsb});
                    m_have_left = 1'b0;
                end
                if (len > SW) begin
                    exp_errs++;
                    m_aligned   = 1'b0;
                    m_have_left = 1'b0;
                end
            end
        end else begin
            m_aligned = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++;
        if (LEFT !== '0) begin errors++; $display("FAIL reset_left got=%h exp=0", LEFT); end
        checks++;
        if (RIGHT !== '0) begin errors++; $display("FAIL reset_right got=%h exp=0", RIGHT); end
        checks++;
        if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", VALID); end
        checks++;
        if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", FRAME_ERR); end
        RST_N = 1'b1;
        model_reset();
        #33;
    endtask

    task automatic test_basic();
        send_slot(1'b1, '0, SW);
        for (int i = 0; i < 3; i++) begin
            send_slot(1'b0, 24'h7FFFFF, SW);
            send_slot(1'b1, 24'h800001, SW);
        end
        repeat (10) @(negedge CLK);
        checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() != 3)
            begin errors++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].l !== 24'h7FFFFF || got_q[i].r !== 24'h800001)
                begin errors++; $display("FAIL basic_pair idx=%0d got=%h/%h exp=7fffff/800001", i, got_q[i].l, got_q[i].r); end
            checks++;
            if (got_q[i].t - exp_q[i].t < 60 || got_q[i].t - exp_q[i].t > 80)
                begin errors++; $display("FAIL basic_latency idx=%0d got=%0t exp=60..80", i, got_q[i].t - exp_q[i].t); end
        end
        checks++;
        if (err_pulses != exp_errs) begin errors++; $display("FAIL basic_err got=%0d exp=%0d", err_pulses, exp_errs); end
        got_q.delete(); exp_q.delete(); err_pulses = 0; exp_errs = 0;
    endtask

    // Shared by the directed-frame and random-frame scenarios: send pairs, compare results
    task automatic test_frames(input string name, input logic [DW-1:0] ls[$], input logic [DW-1:0] rs[$]);
        for (int i = 0; i < ls.size(); i++) begin
            send_slot(1'b0, ls[i], SW);
            send_slot(1'b1, rs[i], SW);
        end
        repeat (10) @(negedge CLK);
        checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() != ls.size())
            begin errors++; $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), ls.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].l !== ls[i] || got_q[i].r !== rs[i])
                begin errors++; $display("FAIL %s_pair idx=%0d got=%h/%h exp=%h/%h", name, i, got_q[i].l, got_q[i].r, ls[i], rs[i]); end
            checks++;
            if (got_q[i].t - exp_q[i].t < 60 || got_q[i].t - exp_q[i].t > 80)
                begin errors++; $display("FAIL %s_latency idx=%0d got=%0t exp=60..80", name, i, got_q[i].t - exp_q[i].t); end
        end
        checks++;
        if (err_pulses != 0) begin errors++; $display("FAIL %s_err got=%0d exp=0", name, err_pulses); end
        got_q.delete(); exp_q.delete(); err_pulses = 0; exp_errs = 0;
    endtask

    task automatic test_truncate();
        logic [DW-1:0] old_l, old_r, l, r;
        old_l = LEFT;
        old_r = RIGHT;
        send_slot(1'b0, 24'($urandom()), 11);
        send_slot(1'b1, 24'($urandom()), SW);
        repeat (4) @(negedge CLK);
        checks++;
        if (LEFT !== old_l || RIGHT !== old_r)
            begin errors++; $display("FAIL trunc_hold got=%h/%h exp=%h/%h", LEFT, RIGHT, old_l, old_r); end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL trunc_no_valid got=%0d exp=0", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            l = 24'($urandom());
            r = 24'($urandom());
            send_slot(1'b0, l, SW);
            send_slot(1'b1, r, SW);
        end
        repeat (10) @(negedge CLK);
        checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() != 2)
            begin errors++; $display("FAIL trunc_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].l !== exp_q[i].l || got_q[i].r !== exp_q[i].r)
                begin errors++; $display("FAIL trunc_pair idx=%0d got=%h/%h exp=%h/%h", i, got_q[i].l, got_q[i].r, exp_q[i].l, exp_q[i].r); end
        end
        checks++;
        if (err_pulses != 1 || exp_errs != 1)
            begin errors++; $display("FAIL trunc_err got=%0d exp=1 model=%0d", err_pulses, exp_errs); end
        got_q.delete(); exp_q.delete(); err_pulses = 0; exp_errs = 0;
    endtask

    task automatic test_reset_mid();
        time t;
        logic [DW-1:0] r;
        send_slot(1'b0, 24'h5A5A5A, SW);
        r = 24'h3C3C3C;
        for (int k = 0; k < 12; k++) drive_bit(1'b1, (k >= 1) ? r[DW-k] : 1'b0, t);
        RST_N = 1'b0;
        #1;
        checks++;
        if (LEFT !== '0 || RIGHT !== '0 || VALID !== 1'b0 || FRAME_ERR !== 1'b0)
            begin errors++; $display("FAIL rstmid_zero got=%h/%h/%b/%b exp=0/0/0/0", LEFT, RIGHT, VALID, FRAME_ERR); end
        repeat (2) @(posedge CLK);
        #3;
        RST_N = 1'b1;
        model_reset();
        send_slot(1'b1, '0, SW - 12);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_early_valid got=%0d exp=0", got_q.size()); end
        send_slot(1'b0, 24'h000ABC, SW);
        send_slot(1'b1, 24'hFFF123, SW);
        repeat (10) @(negedge CLK);
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1)
            begin errors++; $display("FAIL rstmid_count got=%0d exp=1", got_q.size()); end
        else begin
            checks++;
            if (got_q[0].l !== 24'h000ABC || got_q[0].r !== 24'hFFF123)
                begin errors++; $display("FAIL rstmid_pair got=%h/%h exp=000abc/fff123", got_q[0].l, got_q[0].r); end
        end
        got_q.delete(); exp_q.delete(); err_pulses = 0; exp_errs = 0;
    endtask

    task automatic test_pad_timeout();
        send_slot(1'b0, 24'h111111, 2 * SW);
        send_slot(1'b1, 24'h222222, SW);
        checks++;
        if (err_pulses != 1 || got_q.size() != 0)
            begin errors++; $display("FAIL pad_err got=%0d/%0d exp=1/0", err_pulses, got_q.size()); end
        send_slot(1'b0, 24'h654321, SW);
        send_slot(1'b1, 24'h0F0F0F, SW);
        send_slot(1'b0, 24'hF00001, SW);
        send_slot(1'b1, 24'h7FFFFE, SW);
        repeat (10) @(negedge CLK);
        checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() != 2)
            begin errors++; $display("FAIL pad_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].l !== exp_q[i].l || got_q[i].r !== exp_q[i].r)
                begin errors++; $display("FAIL pad_pair idx=%0d got=%h/%h exp=%h/%h", i, got_q[i].l, got_q[i].r, exp_q[i].l, exp_q[i].r); end
        end
        checks++;
        if (err_pulses != exp_errs) begin errors++; $display("FAIL pad_err_total got=%0d exp=%0d", err_pulses, exp_errs); end
        got_q.delete(); exp_q.delete(); err_pulses = 0; exp_errs = 0;
    endtask

    initial begin
        logic [DW-1:0] ls[$];
        logic [DW-1:0] rs[$];
        test_reset();
        test_basic();
        ls = '{24'h000001, 24'h123456, 24'h000000};
        rs = '{24'hFFFFFF, 24'hABCDEF, 24'h000000};
        test_frames("frames", ls, rs);
        ls.delete(); rs.delete();
        for (int i = 0; i < 4; i++) begin
            ls.push_back(24'($urandom()));
            rs.push_back(24'($urandom()));
        end
        test_frames("random", ls, rs);
        test_truncate();
        test_reset_mid();
        test_pad_timeout();
        checks++;
        if (overlaps != 0) begin errors++; $display("FAIL valid_err_overlap got=%0d exp=0", overlaps); end
        checks++;
        if (wide_pulses != 0) begin errors++; $display("FAIL pulse_width got=%0d exp=0", wide_pulses); end
        checks++;
        if (glitches != 0) begin errors++; $display("FAIL output_change_without_valid got=%0d exp=0", glitches); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
